// File: rtl/lv_scan_reg_bist_rsp.sv
// lv_scan_reg_bist_rsp: BIST responder that reads scan registers one per request and checks their stored even parity
module lv_scan_reg_bist_rsp #(
  parameter int LV_SCAN_REG_NUM = 8,
  parameter int REG_DW = 8,
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] SCAN_ADDR_BASE = 8'h40,
  parameter int RD_TMO_TH = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_bist_en,
  input  logic i_bist_scan_reg_req,
  output logic o_scan_reg_bist_ack,
  output logic o_scan_reg_bist_err,
  output logic o_rd_req,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic i_rd_ack,
  input  logic [REG_DW-1:0] i_rd_data,
  input  logic i_rd_par,
  output logic o_fail_flag,
  output logic [$clog2(LV_SCAN_REG_NUM)-1:0] o_fail_idx
);
  localparam int IW = $clog2(LV_SCAN_REG_NUM);
  localparam int TW = $clog2(RD_TMO_TH + 1);
  typedef enum logic [1:0] {IDLE, RD, ACK} state_t;
  state_t state, state_n;
  logic [IW-1:0] idx, idx_n, fail_idx_n;
  logic [TW-1:0] tmo_cnt, tmo_n;
  logic ack_n, err_n, rd_req_n, fail_flag_n, tmo_hit;
  logic [ADDR_W-1:0] rd_addr_n, addr;
  assign addr = SCAN_ADDR_BASE + ADDR_W'(idx);
  assign tmo_hit = tmo_cnt == TW'(RD_TMO_TH - 1);
  // Next state and next registered outputs; disable clears everything without acking
  always_comb begin
    state_n = state;
    idx_n = idx;
    tmo_n = tmo_cnt;
    ack_n = 1'b0;
    err_n = 1'b0;
    rd_req_n = 1'b0;
    rd_addr_n = '0;
    fail_flag_n = o_fail_flag;
    fail_idx_n = o_fail_idx;
    if (!i_bist_en) begin
      state_n = IDLE;
      idx_n = '0;
      tmo_n = '0;
      fail_flag_n = 1'b0;
      fail_idx_n = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n = i_bist_scan_reg_req ? RD : IDLE;
          rd_req_n = i_bist_scan_reg_req;
          rd_addr_n = i_bist_scan_reg_req ? addr : '0;
        end
        RD: begin
          if (i_rd_ack || tmo_hit) begin
            state_n = ACK;
            ack_n = 1'b1;
            err_n = i_rd_ack ? ^{i_rd_data, i_rd_par} : 1'b1;
            fail_flag_n = o_fail_flag | err_n;
            fail_idx_n = (err_n && !o_fail_flag) ? idx : o_fail_idx;
          end else begin
            tmo_n = tmo_cnt + 1'b1;
            rd_req_n = 1'b1;
            rd_addr_n = addr;
          end
        end
        default: begin
          state_n = IDLE;
          idx_n = (idx == IW'(LV_SCAN_REG_NUM - 1)) ? '0 : idx + 1'b1;
          tmo_n = '0;
        end
      endcase
    end
  end
  // State, counters and registered outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      idx <= '0;
      tmo_cnt <= '0;
      o_scan_reg_bist_ack <= 1'b0;
      o_scan_reg_bist_err <= 1'b0;
      o_rd_req <= 1'b0;
      o_rd_addr <= '0;
      o_fail_flag <= 1'b0;
      o_fail_idx <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      tmo_cnt <= tmo_n;
      o_scan_reg_bist_ack <= ack_n;
      o_scan_reg_bist_err <= err_n;
      o_rd_req <= rd_req_n;
      o_rd_addr <= rd_addr_n;
      o_fail_flag <= fail_flag_n;
      o_fail_idx <= fail_idx_n;
    end
  end
endmodule

// File: tb/tb_lv_scan_reg_bist_rsp.sv
// tb_lv_scan_reg_bist_rsp: directed self-checking bench for the scan-register BIST responder
module tb_lv_scan_reg_bist_rsp;
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic i_bist_en = 1'b1;
  logic i_bist_scan_reg_req = 1'b0;
  logic o_scan_reg_bist_ack, o_scan_reg_bist_err, o_rd_req;
  logic [7:0] o_rd_addr;
  logic i_rd_ack = 1'b0;
  logic [7:0] i_rd_data = 8'h00;
  logic i_rd_par = 1'b0;
  logic o_fail_flag;
  logic [2:0] o_fail_idx;
  int errors = 0;
  int checks = 0;
  lv_scan_reg_bist_rsp dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_bist_en(i_bist_en),
    .i_bist_scan_reg_req(i_bist_scan_reg_req),
    .o_scan_reg_bist_ack(o_scan_reg_bist_ack), .o_scan_reg_bist_err(o_scan_reg_bist_err),
    .o_rd_req(o_rd_req), .o_rd_addr(o_rd_addr), .i_rd_ack(i_rd_ack),
    .i_rd_data(i_rd_data), .i_rd_par(i_rd_par),
    .o_fail_flag(o_fail_flag), .o_fail_idx(o_fail_idx)
  );
  always #5 i_clk = ~i_clk;
  // One request: rd_ack pulsed dly cycles after o_rd_req rises (dly<0: never); observations returned
  task automatic txn(input logic [7:0] data, input logic par, input int dly,
                     output logic rq1, output logic [7:0] addr, output int n,
                     output logic got, output logic err, output int lat,
                     output logic req_at_ack, output logic ack_after);
    i_bist_scan_reg_req = 1'b1;
    @(negedge i_clk);
    rq1 = o_rd_req;
    addr = o_rd_addr;
    n = 0;
    got = 1'b0;
    err = 1'b0;
    lat = -1;
    req_at_ack = 1'b1;
    for (int c = 0; c < 40 && !got; c++) begin
      if (o_rd_req) n++;
      i_rd_ack = (dly >= 0 && c == dly);
      i_rd_data = data;
      i_rd_par = par;
      @(negedge i_clk);
      i_rd_ack = 1'b0;
      if (o_scan_reg_bist_ack) begin
        got = 1'b1;
        err = o_scan_reg_bist_err;
        lat = c;
        req_at_ack = o_rd_req;
      end
    end
    i_bist_scan_reg_req = 1'b0;
    @(negedge i_clk);
    ack_after = o_scan_reg_bist_ack;
  endtask
  task automatic window_restart();
    i_bist_en = 1'b0;
    @(negedge i_clk);
    i_bist_en = 1'b1;
    @(negedge i_clk);
  endtask
  task automatic test_reset();
    #1;
    checks++;
    if ({o_scan_reg_bist_ack, o_scan_reg_bist_err, o_rd_req, o_rd_addr, o_fail_flag, o_fail_idx} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs: got ack=%b err=%b rdreq=%b addr=%h flag=%b fidx=%0d, expected all 0",
               o_scan_reg_bist_ack, o_scan_reg_bist_err, o_rd_req, o_rd_addr, o_fail_flag, o_fail_idx);
    end
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
  endtask
  task automatic test_basic_pass();
    logic rq1, got, err, rqa, aa;
    logic [7:0] addr;
    int n, lat;
    for (int k = 0; k < 9; k++) begin
      txn(8'hA5, 1'b0, 3, rq1, addr, n, got, err, lat, rqa, aa);
      checks++;
      if (addr !== 8'h40 + 8'(k % 8) || rq1 !== 1'b1) begin
        errors++;
        $display("FAIL basic_addr[%0d]: got rdreq=%b addr=%h, expected rdreq=1 addr=%h", k, rq1, addr, 8'h40 + 8'(k % 8));
      end
      checks++;
      if (got !== 1'b1 || err !== 1'b0 || lat != 3 || n != 4 || rqa !== 1'b0 || aa !== 1'b0) begin
        errors++;
        $display("FAIL basic_ack[%0d]: got ack=%b err=%b lat=%0d rdreq_cycles=%0d rdreq_at_ack=%b ack_next=%b, expected 1 0 3 4 0 0",
                 k, got, err, lat, n, rqa, aa);
      end
    end
    checks++;
    if (o_fail_flag !== 1'b0) begin
      errors++;
      $display("FAIL basic_flag: got %b, expected 0", o_fail_flag);
    end
  endtask
  task automatic test_parity_fault();
    logic rq1, got, err, rqa, aa;
    logic [7:0] addr;
    int n, lat;
    window_restart();
    for (int k = 0; k < 8; k++) begin
      txn((k == 2 || k == 5) ? 8'h01 : 8'hA5, 1'b0, 3, rq1, addr, n, got, err, lat, rqa, aa);
      checks++;
      if (got !== 1'b1 || err !== (k == 2 || k == 5)) begin
        errors++;
        $display("FAIL parity_err[%0d]: got ack=%b err=%b, expected ack=1 err=%b", k, got, err, (k == 2 || k == 5));
      end
      if (k == 2 || k == 5) begin
        checks++;
        if (o_fail_flag !== 1'b1 || o_fail_idx !== 3'd2) begin
          errors++;
          $display("FAIL parity_capture[%0d]: got flag=%b idx=%0d, expected flag=1 idx=2", k, o_fail_flag, o_fail_idx);
        end
      end
    end
  endtask
  task automatic test_abort();
    logic rq1, got, err, rqa, aa;
    logic [7:0] addr;
    int n, lat;
    i_bist_scan_reg_req = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk);
    i_bist_en = 1'b0;
    @(negedge i_clk);
    i_bist_scan_reg_req = 1'b0;
    checks++;
    if (o_rd_req !== 1'b0 || o_scan_reg_bist_ack !== 1'b0 || o_fail_flag !== 1'b0 || o_fail_idx !== 3'd0) begin
      errors++;
      $display("FAIL abort_clear: got rdreq=%b ack=%b flag=%b idx=%0d, expected all 0",
               o_rd_req, o_scan_reg_bist_ack, o_fail_flag, o_fail_idx);
    end
    @(negedge i_clk);
    checks++;
    if (o_scan_reg_bist_ack !== 1'b0) begin
      errors++;
      $display("FAIL abort_noack: got ack=%b, expected 0", o_scan_reg_bist_ack);
    end
    i_bist_en = 1'b1;
    @(negedge i_clk);
    txn(8'hA5, 1'b0, 2, rq1, addr, n, got, err, lat, rqa, aa);
    checks++;
    if (addr !== 8'h40 || got !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL abort_restart: got addr=%h ack=%b err=%b, expected addr=40 ack=1 err=0", addr, got, err);
    end
  endtask
  task automatic test_timeout();
    logic rq1, got, err, rqa, aa;
    logic [7:0] addr;
    int n, lat;
    window_restart();
    txn(8'hA5, 1'b0, -1, rq1, addr, n, got, err, lat, rqa, aa);
    checks++;
    if (addr !== 8'h40 || n != 16 || got !== 1'b1 || err !== 1'b1 || lat != 15 || rqa !== 1'b0) begin
      errors++;
      $display("FAIL timeout: got addr=%h rdreq_cycles=%0d ack=%b err=%b lat=%0d rdreq_at_ack=%b, expected 40 16 1 1 15 0",
               addr, n, got, err, lat, rqa);
    end
    checks++;
    if (o_fail_flag !== 1'b1 || o_fail_idx !== 3'd0) begin
      errors++;
      $display("FAIL timeout_capture: got flag=%b idx=%0d, expected flag=1 idx=0", o_fail_flag, o_fail_idx);
    end
    i_rd_ack = 1'b1;
    @(negedge i_clk);
    i_rd_ack = 1'b0;
    @(negedge i_clk);
    checks++;
    if (o_scan_reg_bist_ack !== 1'b0 || o_rd_req !== 1'b0) begin
      errors++;
      $display("FAIL stray_ack: got ack=%b rdreq=%b, expected 0 0", o_scan_reg_bist_ack, o_rd_req);
    end
  endtask
  task automatic test_coincidence();
    logic rq1, got, err, rqa, aa;
    logic [7:0] addr;
    int n, lat;
    txn(8'hA5, 1'b0, 15, rq1, addr, n, got, err, lat, rqa, aa);
    checks++;
    if (addr !== 8'h41 || got !== 1'b1 || err !== 1'b0 || lat != 15 || n != 16) begin
      errors++;
      $display("FAIL coincidence: got addr=%h ack=%b err=%b lat=%0d rdreq_cycles=%0d, expected 41 1 0 15 16",
               addr, got, err, lat, n);
    end
  endtask
  task automatic test_async_reset();
    logic rq1, got, err, rqa, aa;
    logic [7:0] addr;
    int n, lat;
    i_bist_scan_reg_req = 1'b1;
    @(negedge i_clk);
    @(posedge i_clk);
    #2;
    i_rst = 1'b1;
    i_bist_scan_reg_req = 1'b0;
    #1;
    checks++;
    if ({o_scan_reg_bist_ack, o_scan_reg_bist_err, o_rd_req, o_rd_addr, o_fail_flag, o_fail_idx} !== 15'd0) begin
      errors++;
      $display("FAIL async_reset: got ack=%b err=%b rdreq=%b addr=%h flag=%b fidx=%0d, expected all 0",
               o_scan_reg_bist_ack, o_scan_reg_bist_err, o_rd_req, o_rd_addr, o_fail_flag, o_fail_idx);
    end
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    txn(8'hA5, 1'b0, 1, rq1, addr, n, got, err, lat, rqa, aa);
    checks++;
    if (rq1 !== 1'b1 || addr !== 8'h40 || got !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_req: got rdreq=%b addr=%h ack=%b err=%b, expected 1 40 1 0", rq1, addr, got, err);
    end
  endtask
  initial begin
    test_reset();
    test_basic_pass();
    test_parity_fault();
    test_abort();
    test_timeout();
    test_coincidence();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lv_scan_reg_bist_rsp.md
Name: lv_scan_reg_bist_rsp

Overview:
Responder side of the LV scan-register BIST handshake. On each BIST request it reads one LV scan register through the register read port and checks the stored even-parity bit. It returns a one-cycle ack with a pass/fail flag. Instantiated in lv_top between the LV BIST controller and the LV register bank; it walks indices 0..LV_SCAN_REG_NUM-1, one per request.

Parameters:
LV_SCAN_REG_NUM, 8, number of scan registers checked per BIST run.
REG_DW, 8, scan register data width.
ADDR_W, 8, register bank address width.
SCAN_ADDR_BASE, 8'h40, address of scan register index 0.
RD_TMO_TH, 16, cycles to wait for i_rd_ack before declaring a read timeout.

Ports:
i_clk  in  1  system clock.
i_rst  in  1  asynchronous active-high reset.
i_bist_en  in  1  BIST window enable; low aborts and clears the block.
i_bist_scan_reg_req  in  1  request from the BIST controller; level, held until ack.
o_scan_reg_bist_ack  out  1  one-cycle ack per request.
o_scan_reg_bist_err  out  1  valid only with ack; 1 = parity error or read timeout.
o_rd_req  out  1  register read request, held until i_rd_ack or timeout.
o_rd_addr  out  ADDR_W  read address = SCAN_ADDR_BASE + idx, truncated to ADDR_W.
i_rd_ack  in  1  read data valid strobe.
i_rd_data  in  REG_DW  register data.
i_rd_par  in  1  stored even-parity bit of the register.
o_fail_flag  out  1  sticky: any error seen in the current BIST window.
o_fail_idx  out  $clog2(LV_SCAN_REG_NUM)  index of the first failing register.

Behaviour:
- Clock and reset: one clock, i_clk. i_rst is asynchronous and active-high. All outputs are registered and reset to 0. The FSM resets to IDLE, and idx and tmo_cnt reset to 0.
- FSM states: IDLE, RD, ACK.
- IDLE:
  - Goes to RD when i_bist_en & i_bist_scan_reg_req.
  - o_rd_req rises on the next cycle, so req-to-rd_req latency is 1 cycle.
- RD:
  - o_rd_req=1 and o_rd_addr=SCAN_ADDR_BASE+idx, both stable.
  - tmo_cnt increments each cycle.
  - On i_rd_ack: err = ^{i_rd_data,i_rd_par}; go to ACK.
  - If tmo_cnt reaches RD_TMO_TH-1 without i_rd_ack: err=1; go to ACK.
  - If i_rd_ack and the timeout coincide, i_rd_ack wins and the parity result is used.
  - o_rd_req drops on the cycle after i_rd_ack or the timeout.
- ACK:
  - Lasts exactly 1 cycle: o_scan_reg_bist_ack=1 and o_scan_reg_bist_err=err; then IDLE.
  - i_rd_ack-to-ack latency is 1 cycle.
  - idx increments; it wraps from LV_SCAN_REG_NUM-1 to 0.
  - tmo_cnt clears.
- Request gap: the controller drops req the cycle after ack. IDLE samples req level only, so no double-service occurs. A req still high in the ACK cycle is ignored.
- Stray acks: i_rd_ack in IDLE or ACK is ignored.
- Error capture: on the first ack with err=1 in a window, o_fail_flag is set and o_fail_idx = idx. Both hold until i_bist_en falls.
- Abort: i_bist_en low in any state forces the following, with no ack issued for the aborted transaction:
  - IDLE next cycle.
  - o_rd_req=0 and o_scan_reg_bist_ack=0.
  - idx, tmo_cnt, o_fail_flag and o_fail_idx cleared.
- Reset mid-transaction: immediate return to the reset values above.
- Outside ACK, o_scan_reg_bist_err is 0.

Test Plan:
- Basic pass, NUM=8: 8 requests, each with i_rd_ack 3 cycles after o_rd_req and good parity (data 8'hA5, par 0) -> 8 acks, all err=0; addresses 0x40..0x47; idx wraps to 0; o_fail_flag=0.
- Parity fault: register idx 2 returns data 8'h01, par 0 -> ack #3 has err=1; o_fail_flag=1; o_fail_idx=2. Then idx 5 also fails -> o_fail_idx stays 2.
- Read timeout: no i_rd_ack for idx 0 -> o_rd_req high exactly 16 cycles; ack with err=1 one cycle later. A late i_rd_ack after that is ignored.
- Coincidence: i_rd_ack arrives on the timeout cycle with good parity -> err=0.
- Abort: i_bist_en drops while in RD -> next cycle o_rd_req=0, no ack, fail state cleared. Re-enable plus req -> o_rd_addr=0x40.
- Async reset: i_rst asserted mid-RD, between clock edges -> all outputs 0 immediately; after release, first req -> o_rd_req one cycle later, addr 0x40.
